// File: rtl/bbox_status_receiver.sv
// bbox_status_receiver
// Rebuilds the fixed 9-byte detection frame that arrives over the vision UART
// link and publishes it to the road-control / overlay logic.
// A frame is four big-endian 16-bit box coordinates (x_min, x_max, y_min, y_max)
// followed by one packed status byte. The first eight bytes are collected into
// shadow registers. The held outputs change only when a complete frame passes
// validation, so downstream logic never sees a half-updated box.
//
// Ports
//   clk              system clock
//   reset            asynchronous assert, active-low reset
//   rx_data[7:0]     received byte, qualified by rx_valid
//   rx_valid         one-cycle strobe per received byte
//   x_min/x_max/y_min/y_max[15:0]  held coordinates of the last good frame
//   traffic_light    0 green, 1 red
//   human_violation  0 none, 1 caution, 2 violation
//   car_violation    0 none, 1 violation
//   traffic_amount   0 low, 1 medium, 2 high
//   frame_valid      one-cycle pulse: held outputs just updated
//   frame_error      one-cycle pulse: complete frame rejected
//   frame_timeout    one-cycle pulse: partial frame dropped after an idle gap
//   busy             a frame is partially received
//   frame_count      good-frame counter (wraps)
//   error_count      rejected + timed-out frame counter (wraps)
module bbox_status_receiver #(
    parameter int GAP_CYCLES = 200000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [15:0] x_min,
    output logic [15:0] x_max,
    output logic [15:0] y_min,
    output logic [15:0] y_max,
    output logic        traffic_light,
    output logic [1:0]  human_violation,
    output logic        car_violation,
    output logic [1:0]  traffic_amount,
    output logic        frame_valid,
    output logic        frame_error,
    output logic        frame_timeout,
    output logic        busy,
    output logic [15:0] frame_count,
    output logic [15:0] error_count
);

    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LIMIT = GAP_W'(GAP_CYCLES - 1);

    typedef enum logic {
        IDLE,
        COLLECT
    } state_t;

    state_t            state_reg, state_next;
    logic [3:0]        byte_idx_reg, byte_idx_next;
    logic [GAP_W-1:0]  gap_cnt_reg, gap_cnt_next;
    logic [7:0]        shadow_reg [8];
    logic [7:0]        shadow_we;

    logic [15:0] x_min_reg, x_min_next;
    logic [15:0] x_max_reg, x_max_next;
    logic [15:0] y_min_reg, y_min_next;
    logic [15:0] y_max_reg, y_max_next;
    logic [5:0]  status_reg, status_next;    // status byte bits [7:2]
    logic        frame_valid_reg, frame_valid_next;
    logic        frame_error_reg, frame_error_next;
    logic        frame_timeout_reg, frame_timeout_next;
    logic [15:0] frame_count_reg, frame_count_next;
    logic [15:0] error_count_reg, error_count_next;

    // Shadow byte gi captures the byte that arrives while byte_idx equals gi.
    // Byte 8 (status) is never stored: it is judged straight off rx_data.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_shadow_we
            assign shadow_we[gi] = rx_valid && (byte_idx_reg == 4'(gi));
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 8; i++) begin
                shadow_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (shadow_we[i]) begin
                    shadow_reg[i] <= rx_data;
                end
            end
        end
    end

    logic [15:0] sh_x_min, sh_x_max, sh_y_min, sh_y_max;
    logic        frame_ok;

    assign sh_x_min = {shadow_reg[0], shadow_reg[1]};
    assign sh_x_max = {shadow_reg[2], shadow_reg[3]};
    assign sh_y_min = {shadow_reg[4], shadow_reg[5]};
    assign sh_y_max = {shadow_reg[6], shadow_reg[7]};

    // Acceptance test for the frame that rx_data (the status byte) completes.
    assign frame_ok = (rx_data[1:0] == 2'b00)
                   && (rx_data[6:5] != 2'b11)
                   && (rx_data[3:2] != 2'b11)
                   && (sh_x_min <= sh_x_max)
                   && (sh_y_min <= sh_y_max);

    always_comb begin
        state_next         = state_reg;
        byte_idx_next      = byte_idx_reg;
        gap_cnt_next       = gap_cnt_reg;
        x_min_next         = x_min_reg;
        x_max_next         = x_max_reg;
        y_min_next         = y_min_reg;
        y_max_next         = y_max_reg;
        status_next        = status_reg;
        frame_valid_next   = 1'b0;
        frame_error_next   = 1'b0;
        frame_timeout_next = 1'b0;
        frame_count_next   = frame_count_reg;
        error_count_next   = error_count_reg;

        case (state_reg)
            IDLE: begin
                // The gap timer only runs while a frame is open.
                gap_cnt_next = '0;
                if (rx_valid) begin
                    byte_idx_next = 4'd1;
                    state_next    = COLLECT;
                end
            end

            COLLECT: begin
                if (rx_valid) begin
                    // A byte on the gap-limit cycle still counts: it wins over the timeout.
                    gap_cnt_next = '0;
                    if (byte_idx_reg == 4'd8) begin
                        byte_idx_next = 4'd0;
                        state_next    = IDLE;
                        if (frame_ok) begin
                            x_min_next       = sh_x_min;
                            x_max_next       = sh_x_max;
                            y_min_next       = sh_y_min;
                            y_max_next       = sh_y_max;
                            status_next      = rx_data[7:2];
                            frame_valid_next = 1'b1;
                            frame_count_next = frame_count_reg + 16'd1;
                        end else begin
                            frame_error_next = 1'b1;
                            error_count_next = error_count_reg + 16'd1;
                        end
                    end else begin
                        byte_idx_next = byte_idx_reg + 4'd1;
                    end
                end else if (gap_cnt_reg == GAP_LIMIT) begin
                    byte_idx_next      = 4'd0;
                    state_next         = IDLE;
                    gap_cnt_next       = '0;
                    frame_timeout_next = 1'b1;
                    error_count_next   = error_count_reg + 16'd1;
                end else begin
                    gap_cnt_next = gap_cnt_reg + 1'b1;
                end
            end

            default: begin
                state_next    = IDLE;
                byte_idx_next = 4'd0;
                gap_cnt_next  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg         <= IDLE;
            byte_idx_reg      <= '0;
            gap_cnt_reg       <= '0;
            x_min_reg         <= '0;
            x_max_reg         <= '0;
            y_min_reg         <= '0;
            y_max_reg         <= '0;
            status_reg        <= '0;
            frame_valid_reg   <= 1'b0;
            frame_error_reg   <= 1'b0;
            frame_timeout_reg <= 1'b0;
            frame_count_reg   <= '0;
            error_count_reg   <= '0;
        end else begin
            state_reg         <= state_next;
            byte_idx_reg      <= byte_idx_next;
            gap_cnt_reg       <= gap_cnt_next;
            x_min_reg         <= x_min_next;
            x_max_reg         <= x_max_next;
            y_min_reg         <= y_min_next;
            y_max_reg         <= y_max_next;
            status_reg        <= status_next;
            frame_valid_reg   <= frame_valid_next;
            frame_error_reg   <= frame_error_next;
            frame_timeout_reg <= frame_timeout_next;
            frame_count_reg   <= frame_count_next;
            error_count_reg   <= error_count_next;
        end
    end

    assign x_min           = x_min_reg;
    assign x_max           = x_max_reg;
    assign y_min           = y_min_reg;
    assign y_max           = y_max_reg;
    assign traffic_light   = status_reg[5];
    assign human_violation = status_reg[4:3];
    assign car_violation   = status_reg[2];
    assign traffic_amount  = status_reg[1:0];
    assign frame_valid     = frame_valid_reg;
    assign frame_error     = frame_error_reg;
    assign frame_timeout   = frame_timeout_reg;
    assign busy            = (state_reg == COLLECT);
    assign frame_count     = frame_count_reg;
    assign error_count     = error_count_reg;

endmodule

// File: tb/tb_bbox_status_receiver.sv
// Directed bench for bbox_status_receiver (gap limit shortened to 16 cycles).
module tb_bbox_status_receiver;

    logic        clk;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [15:0] x_min, x_max, y_min, y_max;
    logic        traffic_light;
    logic [1:0]  human_violation;
    logic        car_violation;
    logic [1:0]  traffic_amount;
    logic        frame_valid, frame_error, frame_timeout, busy;
    logic [15:0] frame_count, error_count;

    bbox_status_receiver #(.GAP_CYCLES(16)) dut (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
        .x_min(x_min), .x_max(x_max), .y_min(y_min), .y_max(y_max),
        .traffic_light(traffic_light), .human_violation(human_violation),
        .car_violation(car_violation), .traffic_amount(traffic_amount),
        .frame_valid(frame_valid), .frame_error(frame_error),
        .frame_timeout(frame_timeout), .busy(busy),
        .frame_count(frame_count), .error_count(error_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int to_pulses = 0;

    always @(posedge clk) begin
        if (frame_timeout) to_pulses <= to_pulses + 1;
    end

    typedef struct packed {
        logic [71:0] frame;   // byte 0 in the top bits
        logic        ok;
        logic [69:0] held;    // {x_min,x_max,y_min,y_max,tl,hv,cv,ta} after the frame
    } vec_t;

    vec_t vecs [8];
    logic [15:0] exp_fc = 16'd0;
    logic [15:0] exp_ec = 16'd0;
    logic [69:0] held_now;

    assign held_now = {x_min, x_max, y_min, y_max, traffic_light,
                       human_violation, car_violation, traffic_amount};

    task automatic chk(input string name, input logic [69:0] act, input logic [69:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Inputs change on the falling edge; the task returns on the next falling
    // edge, so the rising edge that sampled them has already updated outputs.
    task automatic put(input logic v, input logic [7:0] d);
        rx_valid = v;
        rx_data  = d;
        @(negedge clk);
    endtask

    task automatic send_bytes(input logic [71:0] f, input int first, input int last);
        for (int i = first; i <= last; i++) begin
            put(1'b1, f[71-8*i -: 8]);
            if (i < 8) chk("busy_mid_frame", 70'(busy), 70'(1'b1));
        end
        rx_valid = 1'b0;
    endtask

    task automatic chk_counts(input string tag);
        chk({tag, "_frame_count"}, 70'(frame_count), 70'(exp_fc));
        chk({tag, "_error_count"}, 70'(error_count), 70'(exp_ec));
    endtask

    localparam logic [69:0] HELD_A = {16'h0010, 16'h0080, 16'h0020, 16'h0060, 1'b1, 2'd1, 1'b0, 2'd1};
    localparam logic [69:0] HELD_G = {16'h1234, 16'h1234, 16'hFFFF, 16'hFFFF, 1'b0, 2'd2, 1'b1, 2'd2};
    localparam logic [69:0] HELD_H = {16'h0000, 16'hFFFF, 16'h8000, 16'h8001, 1'b0, 2'd0, 1'b0, 2'd0};
    localparam logic [69:0] HELD_B = {16'h0100, 16'h0200, 16'h0300, 16'h0400, 1'b0, 2'd0, 1'b0, 2'd0};
    localparam logic [69:0] HELD_C = {16'h0005, 16'h0006, 16'h0007, 16'h0008, 1'b1, 2'd0, 1'b0, 2'd0};
    localparam logic [69:0] HELD_D = {16'h0011, 16'h0022, 16'h0033, 16'h0044, 1'b0, 2'd1, 1'b0, 2'd1};
    localparam logic [69:0] HELD_E = {16'h1000, 16'h2000, 16'h3000, 16'h4000, 1'b0, 2'd2, 1'b0, 2'd2};

    localparam logic [71:0] FRAME_A = 72'h0010_0080_0020_0060_A4;
    localparam logic [71:0] FRAME_B = 72'h0100_0200_0300_0400_00;
    localparam logic [71:0] FRAME_C = 72'h0005_0006_0007_0008_80;
    localparam logic [71:0] FRAME_D = 72'h0011_0022_0033_0044_24;
    localparam logic [71:0] FRAME_E = 72'h1000_2000_3000_4000_48;

    initial begin
        logic [143:0] pair;
        int to_before;

        vecs[0] = '{frame: FRAME_A,                   ok: 1'b1, held: HELD_A};
        vecs[1] = '{frame: 72'h0010_0080_0020_0060_A5, ok: 1'b0, held: HELD_A}; // reserved=01
        vecs[2] = '{frame: 72'h0010_0080_0020_0060_E0, ok: 1'b0, held: HELD_A}; // human=3
        vecs[3] = '{frame: 72'h0090_0080_0020_0060_A4, ok: 1'b0, held: HELD_A}; // x_min>x_max
        vecs[4] = '{frame: 72'h0010_0080_0061_0060_A4, ok: 1'b0, held: HELD_A}; // y_min>y_max
        vecs[5] = '{frame: 72'h0010_0080_0020_0060_0C, ok: 1'b0, held: HELD_A}; // amount=3
        vecs[6] = '{frame: 72'h1234_1234_FFFF_FFFF_58, ok: 1'b1, held: HELD_G}; // equal bounds
        vecs[7] = '{frame: 72'h0000_FFFF_8000_8001_00, ok: 1'b1, held: HELD_H};

        reset    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (3) @(negedge clk);
        chk("reset_held", held_now, 70'd0);
        chk("reset_pulses_busy", 70'({frame_valid, frame_error, frame_timeout, busy}), 70'd0);
        chk_counts("reset");
        reset = 1'b1;
        @(negedge clk);

        // Table-driven frames, one idle cycle between them.
        for (int r = 0; r < 8; r++) begin
            send_bytes(vecs[r].frame, 0, 8);
            if (vecs[r].ok) exp_fc++; else exp_ec++;
            $display("vector %0d frame=%h valid=%0b error=%0b fc=%0d ec=%0d",
                     r, vecs[r].frame, frame_valid, frame_error, frame_count, error_count);
            chk("vec_frame_valid", 70'(frame_valid), 70'(vecs[r].ok));
            chk("vec_frame_error", 70'(frame_error), 70'(!vecs[r].ok));
            chk("vec_held", held_now, vecs[r].held);
            chk("vec_busy_done", 70'(busy), 70'd0);
            chk_counts("vec");
            put(1'b0, 8'h00);
            chk("vec_pulses_low", 70'({frame_valid, frame_error}), 70'd0);
        end

        // Four bytes, then silence: timeout after the 16th idle cycle.
        send_bytes(FRAME_B, 0, 3);
        for (int k = 0; k < 15; k++) put(1'b0, 8'h00);
        chk("gap15_no_timeout", 70'(frame_timeout), 70'd0);
        chk("gap15_busy", 70'(busy), 70'd1);
        put(1'b0, 8'h00);
        exp_ec++;
        $display("timeout frame_timeout=%0b busy=%0b ec=%0d", frame_timeout, busy, error_count);
        chk("gap16_timeout", 70'(frame_timeout), 70'd1);
        chk("gap16_busy", 70'(busy), 70'd0);
        chk("gap16_held", held_now, HELD_H);
        chk_counts("gap16");
        put(1'b0, 8'h00);
        chk("timeout_pulse_low", 70'(frame_timeout), 70'd0);
        send_bytes(FRAME_B, 0, 8);
        exp_fc++;
        $display("after timeout frame valid=%0b fc=%0d", frame_valid, frame_count);
        chk("post_timeout_valid", 70'(frame_valid), 70'd1);
        chk("post_timeout_held", held_now, HELD_B);
        chk_counts("post_timeout");
        put(1'b0, 8'h00);

        // Byte lands on the gap-limit cycle: it must be accepted.
        to_before = to_pulses;
        send_bytes(FRAME_C, 0, 2);
        for (int k = 0; k < 15; k++) put(1'b0, 8'h00);
        send_bytes(FRAME_C, 3, 8);
        exp_fc++;
        $display("gap-limit frame valid=%0b fc=%0d", frame_valid, frame_count);
        chk("limit_valid", 70'(frame_valid), 70'd1);
        chk("limit_held", held_now, HELD_C);
        chk("limit_no_timeout", 70'(to_pulses - to_before), 70'd0);
        chk_counts("limit");
        put(1'b0, 8'h00);

        // Two frames back-to-back, rx_valid every cycle.
        pair = {FRAME_D, FRAME_E};
        for (int i = 0; i < 18; i++) begin
            put(1'b1, pair[143-8*i -: 8]);
            if (i == 8) begin
                exp_fc++;
                chk("b2b_first_valid", 70'(frame_valid), 70'd1);
                chk("b2b_first_held", held_now, HELD_D);
            end else if (i == 17) begin
                exp_fc++;
                chk("b2b_second_valid", 70'(frame_valid), 70'd1);
                chk("b2b_second_held", held_now, HELD_E);
                chk_counts("b2b");
            end else begin
                chk("b2b_no_valid", 70'(frame_valid), 70'd0);
                if (i > 8) chk("b2b_held_stable", held_now, HELD_D);
            end
        end
        $display("back-to-back second frame fc=%0d", frame_count);
        put(1'b0, 8'h00);

        // Reset in the middle of a frame.
        send_bytes(FRAME_D, 0, 4);
        reset = 1'b0;
        #1;
        exp_fc = 16'd0;
        exp_ec = 16'd0;
        chk("midreset_held", held_now, 70'd0);
        chk("midreset_pulses_busy", 70'({frame_valid, frame_error, frame_timeout, busy}), 70'd0);
        chk_counts("midreset");
        @(negedge clk);
        reset = 1'b1;
        put(1'b0, 8'h00);
        chk("after_reset_quiet", 70'({frame_valid, frame_error, frame_timeout, busy}), 70'd0);
        $display("mid-frame reset fc=%0d ec=%0d", frame_count, error_count);

        // Counter wrap from 0xFFFF.
        force dut.frame_count_reg = 16'hFFFF;
        put(1'b0, 8'h00);
        release dut.frame_count_reg;
        put(1'b0, 8'h00);
        exp_fc = 16'hFFFF;
        chk("preload_count", 70'(frame_count), 70'(exp_fc));
        send_bytes(FRAME_A, 0, 8);
        exp_fc = exp_fc + 16'd1;
        $display("wrap frame valid=%0b fc=%0d", frame_valid, frame_count);
        chk("wrap_valid", 70'(frame_valid), 70'd1);
        chk("wrap_held", held_now, HELD_A);
        chk_counts("wrap");
        put(1'b0, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
